// File: rtl/key_debounce_irq.sv
// Debounced key inputs with press/release event capture, a 4-word register window
// (STATE, PEND, IE, CTRL) and a registered level interrupt.
module key_debounce_irq #(
    parameter int KEY_NUM    = 4,
    parameter int SAMPLE_DIV = 1000,
    parameter int STABLE_CNT = 8,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [KEY_NUM-1:0] key_raw,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic [1:0]         addr,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic [KEY_NUM-1:0] key_state,
    output logic               irq
);
    localparam int PW = $clog2(SAMPLE_DIV);
    localparam int CW = $clog2(STABLE_CNT);
    localparam int EW = 2 * KEY_NUM;
    localparam logic [KEY_NUM-1:0] RELEASED = {KEY_NUM{ACTIVE_LOW}};

    logic [KEY_NUM-1:0] sync1, sync2, sample;
    logic [PW-1:0]      presc;
    logic               tick;
    logic               en;
    logic [CW-1:0]      cnt     [KEY_NUM];
    logic [CW-1:0]      cnt_nxt [KEY_NUM];
    logic [KEY_NUM-1:0] state_nxt, press_ev, release_ev;
    logic [EW-1:0]      pend, ie, pend_clr;
    logic [31:0]        read_val;
    logic               wr_pend, wr_ie, wr_ctrl;
    logic               unused_wdata;

    assign unused_wdata = ^wdata[31:EW];

    // Sync flops reset to the released pin level so no phantom press follows reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= RELEASED;
            sync2 <= RELEASED;
        end else begin
            sync1 <= key_raw;
            sync2 <= sync1;
        end
    end

    assign sample = ACTIVE_LOW ? ~sync2 : sync2;

    assign tick = en && (presc == PW'(SAMPLE_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          presc <= '0;
        else if (!en || tick) presc <= '0;
        else                 presc <= presc + 1'b1;
    end

    // Counter tracks consecutive ticks on which the sample disagrees with key_state.
    always_comb begin
        state_nxt  = key_state;
        press_ev   = '0;
        release_ev = '0;
        for (int k = 0; k < KEY_NUM; k++) begin
            cnt_nxt[k] = cnt[k];
            if (!en) begin
                cnt_nxt[k] = '0;
            end else if (tick) begin
                if (sample[k] == key_state[k]) begin
                    cnt_nxt[k] = '0;
                end else if (cnt[k] == CW'(STABLE_CNT - 1)) begin
                    cnt_nxt[k]    = '0;
                    state_nxt[k]  = sample[k];
                    press_ev[k]   = sample[k];
                    release_ev[k] = ~sample[k];
                end else begin
                    cnt_nxt[k] = cnt[k] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_state <= '0;
            for (int k = 0; k < KEY_NUM; k++) cnt[k] <= '0;
        end else begin
            key_state <= state_nxt;
            for (int k = 0; k < KEY_NUM; k++) cnt[k] <= cnt_nxt[k];
        end
    end

    // Bus: single-cycle wr_en/rd_en strobes, no backpressure; reads return pre-write values.
    assign wr_pend  = wr_en && (addr == 2'd1);
    assign wr_ie    = wr_en && (addr == 2'd2);
    assign wr_ctrl  = wr_en && (addr == 2'd3);
    assign pend_clr = wr_pend ? wdata[EW-1:0] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
            ie   <= '0;
            en   <= 1'b1;
            irq  <= 1'b0;
        end else begin
            pend <= (pend & ~pend_clr) | {release_ev, press_ev};
            if (wr_ie)   ie <= wdata[EW-1:0];
            if (wr_ctrl) en <= wdata[0];
            irq  <= |(pend & ie);
        end
    end

    always_comb begin
        read_val = '0;
        case (addr)
            2'd0:    read_val[KEY_NUM-1:0] = key_state;
            2'd1:    read_val[EW-1:0]      = pend;
            2'd2:    read_val[EW-1:0]      = ie;
            default: read_val[0]           = en;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     rdata <= '0;
        else if (rd_en) rdata <= read_val;
    end
endmodule
